mac_pe_cfg: RTL and testbench

- Parametrised, mode-configurable systolic processing element. It is the next-generation replacement for the fixed 16x8->32 chain PE.
- Forwards ifmap and weight operands east and south with a valid tag, and multiplies the registered operands.
- Mode 0 (CHAIN): adds the product to the incoming partial sum, weight/psum-chain style.
- Mode 1 (OS): accumulates a programmed number of products locally, output-stationary style, then drains the result over a ready/valid handshake.
- Optional signed saturation and a sticky overflow flag.

---
 rtl/mac_pe_cfg.sv | 137 +++++++++++++
 tb/tb_mac_pe_cfg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pe_cfg.sv
// rtl/mac_pe_cfg.sv - mode-configurable systolic MAC processing element (chain psum / output-stationary)
module mac_pe_cfg #(
    parameter int IFMAP_W = 16,
    parameter int W_W     = 8,
    parameter int ACC_W   = 32,
    parameter int LEN_W   = 10,
    parameter bit SAT     = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic                      start,
    input  logic [LEN_W-1:0]          acc_len,
    input  logic                      in_valid,
    input  logic signed [IFMAP_W-1:0] ifmap_in,
    input  logic signed [W_W-1:0]     w_in,
    input  logic signed [ACC_W-1:0]   psum_in,
    input  logic                      psum_ready_in,
    output logic                      valid_out,
    output logic signed [IFMAP_W-1:0] ifmap_out,
    output logic signed [W_W-1:0]     w_out,
    output logic signed [ACC_W-1:0]   psum_out,
    output logic                      psum_valid_out,
    output logic                      busy,
    output logic                      ovf
);

    localparam int P_W = IFMAP_W + W_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state;
    logic [LEN_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc;

    logic signed [P_W-1:0]    prod_full;
    logic signed [ACC_W-1:0]  prod;
    logic [ACC_W:0]           chain_add;
    logic [ACC_W:0]           acc_add;

    // Returns {overflow, result}; the extra MSB of the widened sum is the true sign.
    function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W:0]   s;
        logic             ov;
        logic [ACC_W-1:0] r;
        s  = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        ov = s[ACC_W] ^ s[ACC_W-1];
        r  = s[ACC_W-1:0];
        if (ov && SAT) begin
            r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return {ov, r};
    endfunction

    assign prod_full = P_W'(ifmap_out) * P_W'(w_out);
    assign prod      = ACC_W'(prod_full);
    assign chain_add = add_sat(prod, psum_in);
    assign acc_add   = add_sat(acc, prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out      <= 1'b0;
            ifmap_out      <= '0;
            w_out          <= '0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            busy           <= 1'b0;
            ovf            <= 1'b0;
            acc            <= '0;
            cnt            <= '0;
            state          <= IDLE;
        end else begin
            valid_out <= in_valid;
            if (in_valid) begin
                ifmap_out <= ifmap_in;
                w_out     <= w_in;
            end

            // Once a job is latched the FSM owns the psum path regardless of mode.
            case (state)
                IDLE: begin
                    if (!mode) begin
                        psum_valid_out <= valid_out;
                        if (valid_out) begin
                            psum_out <= chain_add[ACC_W-1:0];
                            if (chain_add[ACC_W]) ovf <= 1'b1;
                        end
                    end else begin
                        psum_valid_out <= 1'b0;
                        if (start) begin
                            acc  <= '0;
                            ovf  <= 1'b0;
                            busy <= 1'b1;
                            if (acc_len != '0) begin
                                cnt   <= acc_len;
                                state <= ACC;
                            end else begin
                                psum_out       <= '0;
                                psum_valid_out <= 1'b1;
                                state          <= DRAIN;
                            end
                        end
                    end
                end
                ACC: begin
                    if (valid_out) begin
                        acc <= acc_add[ACC_W-1:0];
                        cnt <= cnt - LEN_W'(1);
                        if (acc_add[ACC_W]) ovf <= 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            psum_out       <= acc_add[ACC_W-1:0];
                            psum_valid_out <= 1'b1;
                            state          <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (psum_ready_in) begin
                        psum_valid_out <= 1'b0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    psum_valid_out <= 1'b0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_pe_cfg.sv
// tb/tb_mac_pe_cfg.sv - directed self-checking bench for mac_pe_cfg (saturating and wrapping builds)
module tb_mac_pe_cfg;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic               start;
    logic [9:0]         acc_len;
    logic               in_valid;
    logic signed [15:0] ifmap_in;
    logic signed [7:0]  w_in;
    logic signed [31:0] psum_in;
    logic               psum_ready_in;

    logic               valid_out, psum_valid_out, busy, ovf;
    logic signed [15:0] ifmap_out;
    logic signed [7:0]  w_out;
    logic signed [31:0] psum_out;

    logic               valid_out_w, psum_valid_out_w, busy_w, ovf_w;
    logic signed [15:0] ifmap_out_w;
    logic signed [7:0]  w_out_w;
    logic signed [31:0] psum_out_w;

    logic signed [31:0] exp_wrap;
    logic               mode_q = 1'b0;
    int                 n_err = 0;
    int                 n_checks = 0;

    always #5 clk = ~clk;

    mac_pe_cfg #(.IFMAP_W(16), .W_W(8), .ACC_W(32), .LEN_W(10), .SAT(1'b1)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .acc_len(acc_len),
        .in_valid(in_valid), .ifmap_in(ifmap_in), .w_in(w_in), .psum_in(psum_in),
        .psum_ready_in(psum_ready_in), .valid_out(valid_out), .ifmap_out(ifmap_out),
        .w_out(w_out), .psum_out(psum_out), .psum_valid_out(psum_valid_out),
        .busy(busy), .ovf(ovf)
    );

    mac_pe_cfg #(.IFMAP_W(16), .W_W(8), .ACC_W(32), .LEN_W(10), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .acc_len(acc_len),
        .in_valid(in_valid), .ifmap_in(ifmap_in), .w_in(w_in), .psum_in(psum_in),
        .psum_ready_in(psum_ready_in), .valid_out(valid_out_w), .ifmap_out(ifmap_out_w),
        .w_out(w_out_w), .psum_out(psum_out_w), .psum_valid_out(psum_valid_out_w),
        .busy(busy_w), .ovf(ovf_w)
    );

    always @(posedge clk) begin
        if (!rst && busy) assert (mode == mode_q) else $error("mode changed while busy");
        mode_q <= mode;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int a, input int b);
        in_valid = 1'b1;
        ifmap_in = 16'(a);
        w_in     = 8'(b);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; start = 1'b0; acc_len = '0; in_valid = 1'b0;
        ifmap_in = '0; w_in = '0; psum_in = '0; psum_ready_in = 1'b0;
        tick(); tick();
        check("rst_valid_out", valid_out, 0);
        check("rst_ifmap_out", ifmap_out, 0);
        check("rst_psum_out", psum_out, 0);
        check("rst_psum_valid", psum_valid_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        // CHAIN basic
        in_valid = 1'b1; ifmap_in = 16'sd300; w_in = -8'sd5; psum_in = 32'sd0;
        tick();
        check("chain_valid_out", valid_out, 1);
        check("chain_ifmap_out", ifmap_out, 300);
        check("chain_w_out", w_out, -5);
        check("chain_psum_valid_e1", psum_valid_out, 0);
        in_valid = 1'b0; psum_in = 32'sd1000;
        tick();
        check("chain_psum_valid_e2", psum_valid_out, 1);
        check("chain_psum_out", psum_out, -500);
        check("chain_ovf", ovf, 0);
        psum_in = 32'sd7;
        tick();
        check("chain_psum_valid_e3", psum_valid_out, 0);
        check("chain_psum_hold", psum_out, -500);
        check("chain_ifmap_hold", ifmap_out, 300);

        start = 1'b1; acc_len = 10'd3;
        tick();
        start = 1'b0;
        check("chain_start_busy", busy, 0);

        // OS accumulate with bubbles, ignored start in ACC
        mode = 1'b1;
        tick();
        start = 1'b1; acc_len = 10'd3;
        tick();
        start = 1'b0;
        check("os_busy", busy, 1);
        check("os_psum_valid_acc", psum_valid_out, 0);
        op(2, 3);
        tick();
        start = 1'b1; acc_len = 10'd1;
        tick();
        start = 1'b0;
        op(4, -1);
        tick();
        check("os_busy_mid", busy, 1);
        check("os_psum_valid_mid", psum_valid_out, 0);
        op(7, 7);
        tick();
        check("os_drain_valid", psum_valid_out, 1);
        check("os_drain_psum", psum_out, 51);

        // Back-pressure with operands and a start arriving in DRAIN
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; ifmap_in = 16'sd10; w_in = 8'sd10;
            if (i == 2) begin start = 1'b1; acc_len = 10'd5; end
            tick();
            start = 1'b0;
            check("bp_psum_hold", psum_out, 51);
            check("bp_valid_hold", psum_valid_out, 1);
        end
        check("bp_forward", ifmap_out, 10);
        in_valid = 1'b0; psum_ready_in = 1'b1;
        tick();
        psum_ready_in = 1'b0;
        check("os_done_busy", busy, 0);
        check("os_done_valid", psum_valid_out, 0);
        tick();
        check("os_idle_valid", psum_valid_out, 0);

        // Zero length job
        start = 1'b1; acc_len = 10'd0;
        tick();
        start = 1'b0;
        check("zero_busy", busy, 1);
        check("zero_valid", psum_valid_out, 1);
        check("zero_psum", psum_out, 0);
        psum_ready_in = 1'b1;
        tick();
        psum_ready_in = 1'b0;
        check("zero_done_busy", busy, 0);

        // Saturation in CHAIN mode, both builds
        mode = 1'b0;
        tick();
        op(100, 1);
        psum_in = 32'sd2147483638;
        exp_wrap = psum_in + 32'sd100;
        tick();
        check("sat_psum", psum_out, 2147483647);
        check("sat_ovf", ovf, 1);
        check("wrap_psum", psum_out_w, exp_wrap);
        check("wrap_ovf", ovf_w, 1);
        tick();
        check("sat_ovf_sticky", ovf, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_clears_ovf", ovf, 0);
        op(100, 1);
        tick();
        check("sat2_ovf", ovf, 1);

        mode = 1'b1;
        tick();
        start = 1'b1; acc_len = 10'd0;
        tick();
        start = 1'b0;
        check("start_clears_ovf", ovf, 0);
        psum_ready_in = 1'b1;
        tick();
        psum_ready_in = 1'b0;

        // Reset mid-job
        start = 1'b1; acc_len = 10'd4;
        tick();
        start = 1'b0;
        op(3, 3);
        op(3, 3);
        tick();
        check("mid_busy", busy, 1);
        rst = 1'b1; in_valid = 1'b1; ifmap_in = 16'sd9; w_in = 8'sd9;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("mid_rst_valid_out", valid_out, 0);
        check("mid_rst_ifmap", ifmap_out, 0);
        check("mid_rst_w", w_out, 0);
        check("mid_rst_psum", psum_out, 0);
        check("mid_rst_psum_valid", psum_valid_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", ovf, 0);
        start = 1'b1; acc_len = 10'd1;
        tick();
        start = 1'b0;
        op(5, 1);
        tick();
        check("post_rst_valid", psum_valid_out, 1);
        check("post_rst_psum", psum_out, 5);
        psum_ready_in = 1'b1;
        tick();
        psum_ready_in = 1'b0;
        check("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
